meas_avg_filter: RTL and testbench
==================================

// Module: meas_avg_filter
// PURPOSE
//  Block-average filter between the period/amplitude measurer and the BIN12->DEC4 converter.
//  - Takes one 12-bit sample per end-of-measurement strobe (e.g. NTfr on end_Tfr).
//  - Every 2**LOG2N samples, emits the rounded mean and a 1-cycle strobe that drives the converter's st input.
//  - If no sample arrives within TMO_MS ms (no input signal), emits 0 and a timeout flag, so the display does not freeze.
// PARAMETERS
//  W       12   sample/result width
//  LOG2N   3    log2 of block length (N = 8 samples)
//  TMO_MS  500  ce1ms ticks without a sample before a timeout result
// PORTS
//  clk      in   1      system clock
//  rst      in   1      synchronous reset, active-high
//  ce1ms    in   1      1 ms clock-enable pulse
//  st       in   1      sample strobe, 1 clk wide
//  din      in   W      sample, valid when st=1
//  clr      in   1      restart current block (e.g. range/mode switch)
//  dout     out  W      last averaged result
//  dout_st  out  1      1-clk strobe: dout updated
//  tmo      out  1      1 = dout is a timeout result
//  fill     out  LOG2N  samples accumulated in current block
// BEHAVIOUR
//  - Reset: acc=0, fill=0, ms_cnt=0, dout=0, dout_st=0, tmo=0, state=ACC.
//  - Accumulator width W+LOG2N. It cannot overflow.
//  - States:
//    ACC: on st, acc+=din and fill++. On the Nth st (fill=N-1):
//      - dout <= (acc+din+2**(LOG2N-1))>>LOG2N, saturated to 2**W-1
//      - acc,fill <= 0; tmo <= 0; go to OUT.
//    OUT: dout_st=1 for exactly one cycle, then back to ACC.
//      - An st arriving in OUT is accumulated as sample 1 of the next block.
//    TMO: entered from ACC when ms_cnt reaches TMO_MS-1 and ce1ms=1 with st=0.
//      - dout<=0, tmo<=1, acc,fill<=0; dout_st=1 for one cycle, then back to ACC.
//      - tmo stays 1 until the next completed block.
//  - Latency: dout and dout_st are valid on the clock edge after the Nth st (1 cycle).
//  - ms_cnt:
//    - Clears on every st and on clr.
//    - Otherwise increments on ce1ms.
//    - Holds at TMO_MS-1 after a timeout until the next st. No repeated timeout strobes while the signal is absent.
//  - Simultaneous events, priority rst > clr > st > timeout:
//    - clr & st in the same cycle: sample dropped; acc,fill,ms_cnt <= 0; dout/tmo unchanged.
//    - st & timeout-ce1ms in the same cycle: sample taken, no timeout.
//  - clr mid-block discards the partial sum and emits no strobe.
//  - rst mid-block returns all outputs to reset values next edge.
// CONFIGURATION
//  - MEAS_AVG_MINMAX_EN defined: adds outputs dmin[W], dmax[W].
//    - Both track the min/max of raw samples within the block.
//    - Both update with dout on the same edge.
//    - On timeout: dmin=dmax=0.
//    - Reset: dmin=0, dmax=0.
//  - Not defined: ports absent, no comparator logic.
// STRUCTURE
//  - Shared package (meas_pkg.vh): state encodings ST_ACC/ST_OUT/ST_TMO, default W, default TMO_MS.
//  - One sub-module: meas_tmo_cnt (ce1ms timeout counter with clear and hold).
//  - Accumulator/FSM stay in the top.
// TESTING
//  1. 8 st with din=100..107 -> dout=104 (828/8=103.5 rounds up), dout_st one cycle after 8th st, tmo=0.
//  2. 8 st with din=4095 -> dout=4095, no wrap; fill returns to 0.
//  3. 3 samples then no st for 500 ce1ms -> dout=0, tmo=1, single dout_st.
//     - Another 1000 ms idle -> no further strobe.
//     - Next 8 samples of 50 -> dout=50, tmo=0.
//  4. 5 samples of 200, clr, 8 samples of 10 -> dout=10; no strobe at clr.
//     - clr coincident with st -> fill stays 0.
//  5. st on the same cycle as the 500th ce1ms -> no timeout; fill increments.
//  6. MEAS_AVG_MINMAX_EN defined, din=7,3,9,1,5,5,5,5 -> dout=5, dmin=1, dmax=9.
//     - rst asserted mid-block -> all outputs 0 next edge.

Source files
------------

// File: rtl/meas_avg_filter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : meas_avg_filter_pkg
//  Description : Shared constants and FSM state encoding for the block-average
//                measurement filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package meas_avg_filter_pkg;

    localparam int c_W_DEFAULT      = 12;
    localparam int c_LOG2N_DEFAULT  = 3;
    localparam int c_TMO_MS_DEFAULT = 500;

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_OUT = 2'd1,
        ST_TMO = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/meas_avg_filter_if.sv
`default_nettype none
// ============================================================================
//  Module      : meas_avg_filter_if
//  Description : Sample-in / average-out bundle of the block-average filter.
//                MEAS_AVG_MINMAX_EN adds the dmin/dmax result signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface meas_avg_filter_if
    import meas_avg_filter_pkg::*;
#(
    parameter int W     = c_W_DEFAULT,
    parameter int LOG2N = c_LOG2N_DEFAULT
);
    logic             ce1ms;
    logic             st;
    logic [W-1:0]     din;
    logic             clr;
    logic [W-1:0]     dout;
    logic             dout_st;
    logic             tmo;
    logic [LOG2N-1:0] fill;
`ifdef MEAS_AVG_MINMAX_EN
    logic [W-1:0]     dmin;
    logic [W-1:0]     dmax;

    modport master (output ce1ms, st, din, clr,
                    input  dout, dout_st, tmo, fill, dmin, dmax);
    modport slave  (input  ce1ms, st, din, clr,
                    output dout, dout_st, tmo, fill, dmin, dmax);
`else
    modport master (output ce1ms, st, din, clr,
                    input  dout, dout_st, tmo, fill);
    modport slave  (input  ce1ms, st, din, clr,
                    output dout, dout_st, tmo, fill);
`endif
endinterface
`default_nettype wire

// File: rtl/meas_avg_filter_tmo_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : meas_tmo_cnt
//  Description : Millisecond no-signal watchdog. Counts ce1ms ticks since the
//                last clear, fires once when TMO_MS ticks pass, then holds
//                without refiring until the next clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module meas_tmo_cnt
    import meas_avg_filter_pkg::*;
#(
    parameter int TMO_MS = c_TMO_MS_DEFAULT
)(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_ce1ms,
    input  wire logic i_clr,      // sample strobe or block restart
    input  wire logic i_en,       // filter is able to take a timeout now
    output logic      o_expire
);
    localparam int              c_CW      = (TMO_MS > 1) ? $clog2(TMO_MS) : 1;
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(TMO_MS - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_held;
    logic            w_at_max;

    assign w_at_max = (r_cnt == c_CNT_MAX);
    // A clear in the same cycle always wins over the timeout tick.
    assign o_expire = i_en & i_ce1ms & w_at_max & ~r_held & ~i_clr;

    // Tick counter saturating at TMO_MS-1; r_held blocks repeat timeouts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_held <= 1'b0;
        end else if (i_clr) begin
            r_cnt  <= '0;
            r_held <= 1'b0;
        end else if (i_ce1ms) begin
            if (!w_at_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (o_expire) begin
                r_held <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/meas_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module      : meas_avg_filter
//  Description : Block-average filter. Averages 2**LOG2N samples with
//                rounding, strobes the result out, and reports 0 with a
//                timeout flag when no sample arrives for TMO_MS ms.
//                Optional MEAS_AVG_MINMAX_EN adds per-block dmin/dmax.
//  Revision    : 1.0 - initial release
// ============================================================================
module meas_avg_filter
    import meas_avg_filter_pkg::*;
#(
    parameter int W      = c_W_DEFAULT,
    parameter int LOG2N  = c_LOG2N_DEFAULT,
    parameter int TMO_MS = c_TMO_MS_DEFAULT
)(
    input  wire logic         clk,
    input  wire logic         rst,
    meas_avg_filter_if.slave  bus
);
    localparam int               c_AW        = W + LOG2N;
    localparam logic [LOG2N-1:0] c_FILL_LAST = '1;
    localparam logic [c_AW:0]    c_HALF      = (c_AW + 1)'(1) << (LOG2N - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [c_AW-1:0]  r_acc;
    logic [LOG2N-1:0] r_fill;
    logic [W-1:0]     r_dout;
    logic             r_tmo;

    logic             w_take;
    logic             w_last;
    logic             w_expire;
    logic [c_AW:0]    w_sum;
    logic [c_AW:0]    w_mean_full;
    logic [W-1:0]     w_mean;

    // clr drops a coincident sample, so only st without clr is accumulated.
    assign w_take = bus.st & ~bus.clr;
    assign w_last = w_take & (r_fill == c_FILL_LAST);

    // Extra top bit keeps the rounding add from wrapping.
    assign w_sum       = {1'b0, r_acc} + (c_AW + 1)'(bus.din) + c_HALF;
    assign w_mean_full = w_sum >> LOG2N;
    assign w_mean      = (|w_mean_full[c_AW:W]) ? {W{1'b1}} : w_mean_full[W-1:0];

    meas_tmo_cnt #(
        .TMO_MS (TMO_MS)
    ) u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_ce1ms  (bus.ce1ms),
        .i_clr    (bus.st | bus.clr),
        .i_en     (r_state == ST_ACC),
        .o_expire (w_expire)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next state: the result and timeout strobes each last one cycle.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_last) begin
                    w_state_nx = ST_OUT;
                end else if (w_expire) begin
                    w_state_nx = ST_TMO;
                end
            end
            ST_OUT:  w_state_nx = ST_ACC;
            ST_TMO:  w_state_nx = ST_ACC;
            default: w_state_nx = ST_ACC;
        endcase
    end

    // Accumulator, fill count and result registers; samples arriving during
    // the strobe cycle already count toward the next block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_dout <= '0;
            r_tmo  <= 1'b0;
        end else if (bus.clr) begin
            r_acc  <= '0;
            r_fill <= '0;
        end else if (w_last) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_dout <= w_mean;
            r_tmo  <= 1'b0;
        end else if (w_take) begin
            r_acc  <= r_acc + c_AW'(bus.din);
            r_fill <= r_fill + 1'b1;
        end else if (w_expire) begin
            r_acc  <= '0;
            r_fill <= '0;
            r_dout <= '0;
            r_tmo  <= 1'b1;
        end
    end

    assign bus.dout    = r_dout;
    assign bus.tmo     = r_tmo;
    assign bus.fill    = r_fill;
    assign bus.dout_st = (r_state != ST_ACC);

`ifdef MEAS_AVG_MINMAX_EN
    logic [W-1:0] r_run_min;
    logic [W-1:0] r_run_max;
    logic [W-1:0] r_dmin;
    logic [W-1:0] r_dmax;
    logic [W-1:0] w_smp_min;
    logic [W-1:0] w_smp_max;

    // The first sample of a block seeds both running extremes.
    assign w_smp_min = ((r_fill == '0) || (bus.din < r_run_min)) ? bus.din : r_run_min;
    assign w_smp_max = ((r_fill == '0) || (bus.din > r_run_max)) ? bus.din : r_run_max;

    // Running min/max per block, published alongside dout.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_min <= '0;
            r_run_max <= '0;
            r_dmin    <= '0;
            r_dmax    <= '0;
        end else if (!bus.clr) begin
            if (w_take) begin
                r_run_min <= w_smp_min;
                r_run_max <= w_smp_max;
            end
            if (w_last) begin
                r_dmin <= w_smp_min;
                r_dmax <= w_smp_max;
            end else if (!w_take && w_expire) begin
                r_dmin <= '0;
                r_dmax <= '0;
            end
        end
    end

    assign bus.dmin = r_dmin;
    assign bus.dmax = r_dmax;
`else
    // Without min/max tracking the block publishes only the mean.
`endif

endmodule
`default_nettype wire

// File: tb/tb_meas_avg_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_meas_avg_filter
//  Description : Directed self-checking bench for meas_avg_filter with an
//                expected-result queue popped on every dout_st strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_meas_avg_filter;

    localparam int W = 12;

    typedef struct packed {
        logic [W-1:0] dout;
        logic         tmo;
        logic [W-1:0] dmin;
        logic [W-1:0] dmax;
    } exp_t;

    logic   clk;
    logic   rst;
    int     n_checks;
    int     n_fail;
    int     n_strobes;
    exp_t   sb[$];
    exp_t   e_mon;
    logic [W-1:0] blk [8];
    int     s0;

    meas_avg_filter_if #(.W(W), .LOG2N(3)) bus ();

    meas_avg_filter #(
        .W      (W),
        .LOG2N  (3),
        .TMO_MS (500)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest pending result.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.dout_st === 1'b1) begin
            n_strobes++;
            n_checks++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_strobe observed=strobe expected=no_strobe");
            end
            if (sb.size() != 0) begin
                e_mon = sb.pop_front();
                check("sb_dout", 32'(bus.dout), 32'(e_mon.dout));
                check("sb_tmo", 32'(bus.tmo), 32'(e_mon.tmo));
`ifdef MEAS_AVG_MINMAX_EN
                check("sb_dmin", 32'(bus.dmin), 32'(e_mon.dmin));
                check("sb_dmax", 32'(bus.dmax), 32'(e_mon.dmax));
`endif
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        bus.st  = 1'b1;
        bus.din = d;
        @(negedge clk);
        bus.st  = 1'b0;
        bus.din = '0;
    endtask

    task automatic pulse_ms(input int n);
        for (int i = 0; i < n; i++) begin
            bus.ce1ms = 1'b1;
            @(negedge clk);
            bus.ce1ms = 1'b0;
        end
    endtask

    // Drive blk[0..7] as one block; result is modelled and queued up front.
    task automatic send_block(input string tag);
        int   sum;
        int   mean;
        exp_t e;
        sum    = 0;
        e.dmin = blk[0];
        e.dmax = blk[0];
        for (int i = 0; i < 8; i++) begin
            sum += int'(blk[i]);
            if (blk[i] < e.dmin) e.dmin = blk[i];
            if (blk[i] > e.dmax) e.dmax = blk[i];
        end
        mean   = (sum + 4) / 8;
        e.dout = (mean > 4095) ? 12'hFFF : W'(mean);
        e.tmo  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) sb.push_back(e);
            send(blk[i]);
        end
        check({tag, "_strobe"}, 32'(bus.dout_st), 32'd1);
        check({tag, "_dout"}, 32'(bus.dout), 32'(e.dout));
        check({tag, "_fill"}, 32'(bus.fill), 32'd0);
        @(negedge clk);
        check({tag, "_strobe_off"}, 32'(bus.dout_st), 32'd0);
    endtask

    initial begin
        exp_t et;
        n_checks  = 0;
        n_fail    = 0;
        n_strobes = 0;
        rst       = 1'b1;
        bus.ce1ms = 1'b0;
        bus.st    = 1'b0;
        bus.din   = '0;
        bus.clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_strobe", 32'(bus.dout_st), 32'd0);
        check("rst_tmo", 32'(bus.tmo), 32'd0);
        check("rst_fill", 32'(bus.fill), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp 100..107 rounds 103.5 up to 104.
        for (int i = 0; i < 8; i++) blk[i] = W'(100 + i);
        send_block("ramp");
        check("ramp_tmo", 32'(bus.tmo), 32'd0);

        // Full-scale samples must not wrap.
        for (int i = 0; i < 8; i++) blk[i] = 12'hFFF;
        send_block("full");

        // Timeout after three samples and 500 idle ticks.
        send(12'd30); send(12'd31); send(12'd32);
        s0 = n_strobes;
        pulse_ms(499);
        check("tmo_early_fill", 32'(bus.fill), 32'd3);
        check("tmo_early_strobe", 32'(bus.dout_st), 32'd0);
        et = '{dout: '0, tmo: 1'b1, dmin: '0, dmax: '0};
        sb.push_back(et);
        pulse_ms(1);
        check("tmo_strobe", 32'(bus.dout_st), 32'd1);
        check("tmo_fill", 32'(bus.fill), 32'd0);
        @(negedge clk);
        check("tmo_strobe_count", 32'(n_strobes), 32'(s0 + 1));
        pulse_ms(1000);
        @(negedge clk);
        check("tmo_no_repeat", 32'(n_strobes), 32'(s0 + 1));
        check("tmo_held", 32'(bus.tmo), 32'd1);
        for (int i = 0; i < 8; i++) blk[i] = 12'd50;
        send_block("recover");
        check("recover_tmo", 32'(bus.tmo), 32'd0);

        // clr mid-block discards the partial sum silently.
        for (int i = 0; i < 5; i++) send(12'd200);
        s0 = n_strobes;
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
        check("clr_fill", 32'(bus.fill), 32'd0);
        @(negedge clk);
        check("clr_no_strobe", 32'(n_strobes), 32'(s0));
        check("clr_dout_kept", 32'(bus.dout), 32'd50);
        for (int i = 0; i < 8; i++) blk[i] = 12'd10;
        send_block("after_clr");

        // clr together with st drops the sample.
        send(12'd7); send(12'd8);
        bus.clr = 1'b1;
        bus.st  = 1'b1;
        bus.din = 12'd99;
        @(negedge clk);
        bus.clr = 1'b0;
        bus.st  = 1'b0;
        bus.din = '0;
        check("clr_st_fill", 32'(bus.fill), 32'd0);
        check("clr_st_dout", 32'(bus.dout), 32'd10);

        // st on the 500th tick wins over the timeout.
        send(12'd20);
        pulse_ms(499);
        s0 = n_strobes;
        bus.st    = 1'b1;
        bus.din   = 12'd20;
        bus.ce1ms = 1'b1;
        @(negedge clk);
        bus.st    = 1'b0;
        bus.din   = '0;
        bus.ce1ms = 1'b0;
        check("race_fill", 32'(bus.fill), 32'd2);
        check("race_strobe", 32'(bus.dout_st), 32'd0);
        @(negedge clk);
        check("race_no_strobe", 32'(n_strobes), 32'(s0));
        check("race_tmo", 32'(bus.tmo), 32'd0);
        et = '{dout: 12'd20, tmo: 1'b0, dmin: 12'd20, dmax: 12'd20};
        for (int i = 0; i < 6; i++) begin
            if (i == 5) sb.push_back(et);
            send(12'd20);
        end
        check("race_block_strobe", 32'(bus.dout_st), 32'd1);
        @(negedge clk);

`ifdef MEAS_AVG_MINMAX_EN
        blk = '{12'd7, 12'd3, 12'd9, 12'd1, 12'd5, 12'd5, 12'd5, 12'd5};
        send_block("minmax");
        check("minmax_dmin", 32'(bus.dmin), 32'd1);
        check("minmax_dmax", 32'(bus.dmax), 32'd9);
`endif

        // Reset in the middle of a block.
        send(12'd300); send(12'd301); send(12'd302);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_dout", 32'(bus.dout), 32'd0);
        check("mid_rst_fill", 32'(bus.fill), 32'd0);
        check("mid_rst_tmo", 32'(bus.tmo), 32'd0);
        check("mid_rst_strobe", 32'(bus.dout_st), 32'd0);
`ifdef MEAS_AVG_MINMAX_EN
        check("mid_rst_dmin", 32'(bus.dmin), 32'd0);
        check("mid_rst_dmax", 32'(bus.dmax), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
